// File: rtl/key_entry_buffer.sv
// Debounced keypad front end: builds a BCD entry and commits it over valid/ready.
// Optional auto-repeat of held digit keys is enabled by defining KEY_REPEAT_EN.
module key_entry_buffer #(
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REPEAT_SCANS   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         key,
    input  logic                tc,
    output logic                code_valid,
    output logic [3:0]          code,
    output logic [4*DIGITS-1:0] entry,
    output logic [3:0]          count,
    output logic                err,
    output logic [4*DIGITS-1:0] value,
    output logic                value_valid,
    input  logic                value_ready
);
    localparam logic [3:0]  LP_DB  = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0]  LP_DIG = 4'(DIGITS);
    // Nibble k holds the code of key bit k.
    localparam logic [63:0] LP_MAP = 64'hDF0E_C987_B654_A321;

    if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 || DIGITS < 1 || DIGITS > 8 ||
        REPEAT_SCANS < 4) begin : g_bad_param
        $error("key_entry_buffer: parameter out of range");
    end

    typedef enum logic {S_IDLE, S_HELD} state_t;
    state_t r_state, w_state_nx;

    logic                r_armed;
    logic [15:0]         r_prev;
    logic [3:0]          r_stable, w_stable_nx;
    logic                w_tc, w_accept, w_onehot;
    logic [3:0]          w_map_code;
    logic                w_fire;
    logic [3:0]          w_fire_code;
    logic                r_code_valid, r_err, r_value_valid;
    logic [3:0]          r_code, r_count;
    logic [4*DIGITS-1:0] r_entry, r_value;
    logic [4*DIGITS+3:0] w_cat;

    assign w_tc     = tc & r_armed;
    assign w_onehot = (key != '0) && ((key & (key - 16'd1)) == '0);

    always_comb begin
        w_map_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (key[i]) w_map_code = LP_MAP[4*i +: 4];
        end
    end

    always_comb begin
        if (key != r_prev)          w_stable_nx = 4'd1;
        else if (r_stable == 4'hF)  w_stable_nx = 4'hF;
        else                        w_stable_nx = r_stable + 4'd1;
    end

    // Acceptance fires only on the scan where the run first reaches the threshold.
    assign w_accept = w_tc && (w_stable_nx == LP_DB) && (r_stable != LP_DB);

`ifdef KEY_REPEAT_EN
    localparam logic [15:0] LP_REP_FIRST = 16'(REPEAT_SCANS);
    localparam logic [15:0] LP_REP_NEXT  = 16'(REPEAT_SCANS / 4);

    logic        r_rep_on, r_rep_first;
    logic [15:0] r_rep_cnt, w_rep_cnt_nx;
    logic [3:0]  r_held_code;
    logic        w_rep_fire;

    assign w_rep_cnt_nx = r_rep_cnt + 16'd1;
    assign w_rep_fire   = w_tc && r_rep_on &&
                          (w_rep_cnt_nx == (r_rep_first ? LP_REP_FIRST : LP_REP_NEXT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_on    <= 1'b0;
            r_rep_first <= 1'b1;
            r_rep_cnt   <= '0;
            r_held_code <= '0;
        end else if (w_tc) begin
            if (w_accept) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
                r_rep_on    <= (r_state == S_IDLE) && w_onehot && (w_map_code <= 4'd9);
                if (r_state == S_IDLE) r_held_code <= w_map_code;
            end else if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else if (r_rep_on) begin
                r_rep_cnt   <= w_rep_cnt_nx;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_fire      = 1'b0;
        w_fire_code = w_map_code;
        if (w_accept) begin
            case (r_state)
                S_IDLE: if (w_onehot) begin
                    w_state_nx = S_HELD;
                    w_fire     = 1'b1;
                end
                S_HELD: if (!w_onehot) w_state_nx = S_IDLE;
            endcase
        end
`ifdef KEY_REPEAT_EN
        else if (w_rep_fire) begin
            w_fire      = 1'b1;
            w_fire_code = r_held_code;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_prev   <= '0;
            r_stable <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_tc) begin
                r_prev   <= key;
                r_stable <= w_stable_nx;
            end
        end
    end

    assign w_cat = {r_entry, w_fire_code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_valid  <= 1'b0;
            r_code        <= '0;
            r_err         <= 1'b0;
            r_entry       <= '0;
            r_count       <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_err        <= 1'b0;
            if (r_value_valid && value_ready) r_value_valid <= 1'b0;
            if (w_fire) begin
                r_code_valid <= 1'b1;
                r_code       <= w_fire_code;
                if (w_fire_code <= 4'd9) begin
                    if (r_count < LP_DIG) begin
                        r_entry <= w_cat[4*DIGITS-1:0];
                        r_count <= r_count + 4'd1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end else begin
                    case (w_fire_code)
                        4'hA: if (r_count != '0) begin
                            r_entry <= r_entry >> 4;
                            r_count <= r_count - 4'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        4'hE: begin
                            r_entry <= '0;
                            r_count <= '0;
                        end
                        4'hF: if (r_count != '0 && (!r_value_valid || value_ready)) begin
                            r_value       <= r_entry;
                            r_value_valid <= 1'b1;
                            r_entry       <= '0;
                            r_count       <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign code_valid  = r_code_valid;
    assign code        = r_code;
    assign err         = r_err;
    assign entry       = r_entry;
    assign count       = r_count;
    assign value       = r_value;
    assign value_valid = r_value_valid;
endmodule
